// File: rtl/mux_sel_ctrl.sv
// rtl/mux_sel_ctrl.sv - debounced push-button select toggle for the 2:1 mux stage
// Optional free-running scan toggle enabled by defining MUX_AUTO_SCAN_EN.
module mux_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int SCAN_CYCLES     = 50000000,
  parameter int SCAN_W          = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  input  logic en,
`ifdef MUX_AUTO_SCAN_EN
  input  logic auto_scan,
`endif
  output logic sel,
  output logic sel_valid,
  output logic btn_db
);

  typedef enum logic [1:0] {IDLE, ARM_P, HELD, ARM_R} state_t;

  state_t           state_q, state_d;
  logic             sync1_q;
  logic             btn_s_q;
  logic             btn_db_q, btn_db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;
  logic             done;
  logic             expire;
  logic             toggle;
`ifdef MUX_AUTO_SCAN_EN
  logic [SCAN_W-1:0] scan_q, scan_d;
`endif

  assign done = (btn_s_q != btn_db_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_comb begin
    cnt_d    = cnt_q;
    btn_db_d = btn_db_q;
    if (btn_s_q == btn_db_q) begin
      cnt_d = '0;
    end else if (done) begin
      cnt_d    = '0;
      btn_db_d = btn_s_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The FSM only qualifies the counter's done as a press; releases never toggle.
  always_comb begin
    state_d = state_q;
    press_d = 1'b0;
    case (state_q)
      IDLE:  if (!btn_s_q) state_d = ARM_P;
      ARM_P: begin
        if (btn_s_q) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = HELD;
          press_d = en;
        end
      end
      HELD:  if (btn_s_q) state_d = ARM_R;
      ARM_R: begin
        if (!btn_s_q)  state_d = HELD;
        else if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    expire = 1'b0;
`ifdef MUX_AUTO_SCAN_EN
    scan_d = '0;
    // A press restarts the scan period and wins over a simultaneous expiry.
    if (auto_scan && en && !press_q) begin
      if (scan_q == SCAN_W'(SCAN_CYCLES - 1)) begin
        expire = 1'b1;
      end else begin
        scan_d = scan_q + SCAN_W'(1);
      end
    end
`endif
    toggle      = press_q | expire;
    sel_d       = sel_q ^ toggle;
    sel_valid_d = toggle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      btn_s_q     <= 1'b1;
      btn_db_q    <= 1'b1;
      cnt_q       <= '0;
      state_q     <= IDLE;
      press_q     <= 1'b0;
      sel_q       <= 1'b0;
      sel_valid_q <= 1'b0;
`ifdef MUX_AUTO_SCAN_EN
      scan_q      <= '0;
`endif
    end else begin
      sync1_q     <= btn_n;
      btn_s_q     <= sync1_q;
      btn_db_q    <= btn_db_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      press_q     <= press_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
`ifdef MUX_AUTO_SCAN_EN
      scan_q      <= scan_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign btn_db    = btn_db_q;

endmodule
